// File: rtl/button_press_scheduler_if.sv
// Press-event channel between the button scheduler and its consumer.
interface button_press_scheduler_if #(
    parameter int unsigned N_BUTTONS = 4,
    parameter int unsigned ID_W      = 2
);
    logic [N_BUTTONS-1:0] button;
    logic                 evt_ready;
    logic                 evt_valid;
    logic [ID_W-1:0]      evt_id;
    logic [N_BUTTONS-1:0] stateful;
    logic [N_BUTTONS-1:0] pending;
    logic [7:0]           drop_count;

    modport master (
        output button, evt_ready,
        input  evt_valid, evt_id, stateful, pending, drop_count
    );

    modport slave (
        input  button, evt_ready,
        output evt_valid, evt_id, stateful, pending, drop_count
    );
endinterface

// File: rtl/button_press_scheduler.sv
// Debounces N raw buttons, queues one press per button and issues them
// round-robin over a valid/ready channel, toggling a per-button bit on accept.
module button_press_scheduler #(
    parameter int unsigned N_BUTTONS = 4,
    parameter int unsigned DEBOUNCE  = 4,
    parameter int unsigned ID_W      = 2
) (
    input logic                     clk,
    input logic                     reset,
    button_press_scheduler_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t               state, state_n;
    logic [N_BUTTONS-1:0] sync1, sync2;
    logic [N_BUTTONS-1:0] db, db_n, press_c;
    logic [CNT_W-1:0]     cnt [N_BUTTONS];
    logic [CNT_W-1:0]     cnt_n [N_BUTTONS];
    logic [CNT_W:0]       cnt_inc_c;

    logic [ID_W-1:0]      evt_id, evt_id_n;
    logic [ID_W-1:0]      last_grant, last_grant_n;
    logic [N_BUTTONS-1:0] stateful, stateful_n;
    logic [N_BUTTONS-1:0] pending, pending_n;
    logic [7:0]           drop_count, drop_count_n;

    logic                 accept_c;
    logic                 grant_found_c;
    logic [ID_W-1:0]      grant_id_c;
    int unsigned          idx_c;
    logic [N_BUTTONS-1:0] issue_mask_c;
    logic [N_BUTTONS-1:0] drop_c;
    logic [8:0]           drop_sum_c;

    // Per-button debounce counters; a press is the 0->1 flip of the debounced level.
    always_comb begin
        db_n      = db;
        press_c   = '0;
        cnt_inc_c = '0;
        for (int i = 0; i < int'(N_BUTTONS); i++) begin
            cnt_n[i]  = '0;
            cnt_inc_c = {1'b0, cnt[i]} + (CNT_W + 1)'(1);
            if (sync2[i] != db[i]) begin
                if (cnt_inc_c == (CNT_W + 1)'(DEBOUNCE)) begin
                    db_n[i]    = ~db[i];
                    press_c[i] = ~db[i];
                end else begin
                    cnt_n[i] = cnt_inc_c[CNT_W-1:0];
                end
            end
        end
    end

    // Round-robin search starting just after the last granted button.
    always_comb begin
        grant_found_c = 1'b0;
        grant_id_c    = '0;
        idx_c         = 0;
        for (int k = 0; k < int'(N_BUTTONS); k++) begin
            idx_c = (int'(last_grant) + 1 + k) % N_BUTTONS;
            if (!grant_found_c && pending[idx_c]) begin
                grant_found_c = 1'b1;
                grant_id_c    = ID_W'(idx_c);
            end
        end
    end

    // Issue FSM next-state, pending queue, toggle bits and drop counter.
    always_comb begin
        state_n      = state;
        evt_id_n     = evt_id;
        last_grant_n = last_grant;
        stateful_n   = stateful;
        issue_mask_c = '0;
        accept_c     = (state == PRESENT) && bus.evt_ready;

        for (int i = 0; i < int'(N_BUTTONS); i++) begin
            if (accept_c && (ID_W'(i) == evt_id)) begin
                stateful_n[i] = ~stateful[i];
            end
        end

        if ((state == IDLE) || accept_c) begin
            if (grant_found_c) begin
                state_n      = PRESENT;
                evt_id_n     = grant_id_c;
                last_grant_n = grant_id_c;
                for (int i = 0; i < int'(N_BUTTONS); i++) begin
                    if (ID_W'(i) == grant_id_c) begin
                        issue_mask_c[i] = 1'b1;
                    end
                end
            end else begin
                state_n = IDLE;
            end
        end

        // A press coinciding with its own issue re-queues rather than drops.
        drop_c     = press_c & pending & ~issue_mask_c;
        pending_n  = (pending & ~issue_mask_c) | press_c;
        drop_sum_c = {1'b0, drop_count};
        for (int i = 0; i < int'(N_BUTTONS); i++) begin
            drop_sum_c = drop_sum_c + 9'(drop_c[i]);
        end
        drop_count_n = (drop_sum_c > 9'd255) ? 8'd255 : drop_sum_c[7:0];
    end

    // Two-flop synchroniser plus debounce state.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            for (int i = 0; i < int'(N_BUTTONS); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= bus.button;
            sync2 <= sync1;
            db    <= db_n;
            for (int i = 0; i < int'(N_BUTTONS); i++) begin
                cnt[i] <= cnt_n[i];
            end
        end
    end

    // FSM state register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            evt_id     <= '0;
            last_grant <= ID_W'(N_BUTTONS - 1);
            stateful   <= '0;
            pending    <= '0;
            drop_count <= '0;
        end else begin
            state      <= state_n;
            evt_id     <= evt_id_n;
            last_grant <= last_grant_n;
            stateful   <= stateful_n;
            pending    <= pending_n;
            drop_count <= drop_count_n;
        end
    end

    assign bus.evt_valid  = (state == PRESENT);
    assign bus.evt_id     = evt_id;
    assign bus.stateful   = stateful;
    assign bus.pending    = pending;
    assign bus.drop_count = drop_count;
endmodule

// File: tb/tb_button_press_scheduler.sv
// Bench for button_press_scheduler: directed scenarios plus random bouncing
// buttons, all compared every cycle against a behavioural model.
module tb_button_press_scheduler;
    localparam int unsigned N  = 4;
    localparam int unsigned DB = 4;
    localparam int unsigned IW = 2;

    logic clk = 1'b0;
    logic reset;

    button_press_scheduler_if #(.N_BUTTONS(N), .ID_W(IW)) bus ();

    button_press_scheduler #(.N_BUTTONS(N), .DEBOUNCE(DB), .ID_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state.
    bit [N-1:0] m_s1, m_s2, m_db, m_pend, m_stateful;
    int         m_run [N];
    bit         m_valid;
    int         m_id, m_last, m_drops;
    bit         m_primed = 1'b0;

    logic [N-1:0] cur_b;
    logic         cur_r;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Effect of one clock edge on the model, given inputs held over that edge.
    task automatic model_edge(input bit [N-1:0] b, input bit r, input bit rs);
        bit [N-1:0] press;
        int         grant;
        if (rs) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_pend = '0; m_stateful = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
            m_valid = 1'b0; m_id = 0; m_last = N - 1; m_drops = 0;
            return;
        end
        press = '0;
        for (int i = 0; i < N; i++) begin
            if (m_s2[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] >= DB) begin
                    press[i] = !m_db[i];
                    m_db[i]  = !m_db[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = b;
        if (m_valid && r) m_stateful[m_id] = !m_stateful[m_id];
        if (!m_valid || r) begin
            grant = -1;
            for (int k = 1; k <= N; k++) begin
                if (m_pend[(m_last + k) % N]) begin
                    grant = (m_last + k) % N;
                    break;
                end
            end
            if (grant >= 0) begin
                m_pend[grant] = 1'b0;
                m_valid = 1'b1; m_id = grant; m_last = grant;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (press[i]) begin
                if (m_pend[i] && m_drops < 255) m_drops++;
                m_pend[i] = 1'b1;
            end
        end
    endtask

    task automatic compare_model();
        check("evt_valid", 32'(bus.evt_valid), 32'(m_valid));
        check("evt_id", 32'(bus.evt_id), 32'(m_id));
        check("stateful", 32'(bus.stateful), 32'(m_stateful));
        check("pending", 32'(bus.pending), 32'(m_pend));
        check("drop_count", 32'(bus.drop_count), 32'(m_drops));
    endtask

    // Compare at the falling edge, then drive inputs for the next rising edge.
    task automatic step(input logic [N-1:0] b, input logic r, input logic rs);
        @(negedge clk);
        if (m_primed) compare_model();
        bus.button = b; bus.evt_ready = r; reset = rs;
        cur_b = b; cur_r = r;
        model_edge(b, r, rs);
        m_primed = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40 && !bus.evt_valid; i++) step(cur_b, cur_r, 1'b0);
        check(tag, 32'(bus.evt_valid), 32'd1);
    endtask

    task automatic do_reset();
        step(cur_b, cur_r, 1'b1);
        step(cur_b, cur_r, 1'b1);
    endtask

    int          ids [$];
    int          lat, cnt_ev;
    bit          seen;
    logic [N-1:0] b_rand, level;

    initial begin
        bus.button = '0; bus.evt_ready = 1'b0; reset = 1'b1;
        cur_b = '0; cur_r = 1'b0;

        // Reset with all buttons held: outputs 0, then grants 0,1,2,3.
        step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b1);
        check("rst_valid", 32'(bus.evt_valid), 32'd0);
        check("rst_stateful", 32'(bus.stateful), 32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_drops", 32'(bus.drop_count), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step(4'b1111, 1'b1, 1'b0);
            if (bus.evt_valid) ids.push_back(int'(bus.evt_id));
        end
        check("rst_order_n", 32'(ids.size()), 32'd4);
        for (int i = 0; i < 4 && i < ids.size(); i++) check("rst_order_id", 32'(ids[i]), 32'(i));
        check("rst_all_toggled", 32'(bus.stateful), 32'hF);
        for (int i = 0; i < 12; i++) step(4'b0000, 1'b1, 1'b0);

        // Glitch on button 2 must not produce an event.
        seen = 1'b0;
        step(4'b0100, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(4'b0000, 1'b1, 1'b0);
            if (bus.evt_valid || bus.pending != 0) seen = 1'b1;
        end
        check("glitch_no_event", 32'(seen), 32'd0);

        // Held press: exactly one event, DEBOUNCE+2 edges after first sample.
        step(4'b0100, 1'b1, 1'b0);
        lat = -1; cnt_ev = 0;
        for (int i = 0; i < 20; i++) begin
            step(4'b0100, 1'b1, 1'b0);
            if (bus.evt_valid) begin
                if (lat < 0) lat = i;
                if (bus.evt_id == 2'd2) cnt_ev++;
            end
        end
        check("latency", 32'(lat), 32'(DB + 2));
        check("held_one_event", 32'(cnt_ev), 32'd1);
        for (int i = 0; i < 12; i++) step(4'b0000, 1'b1, 1'b0);

        // Backpressure on button 1.
        do_reset();
        step(4'b0010, 1'b0, 1'b0);
        wait_valid("bp_wait");
        for (int i = 0; i < 5; i++) begin
            step(4'b0010, 1'b0, 1'b0);
            check("bp_hold_valid", 32'(bus.evt_valid), 32'd1);
            check("bp_hold_id", 32'(bus.evt_id), 32'd1);
            check("bp_no_toggle", 32'(bus.stateful[1]), 32'd0);
        end
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        check("bp_toggled", 32'(bus.stateful[1]), 32'd1);
        check("bp_valid_low", 32'(bus.evt_valid), 32'd0);

        // Round-robin: button 0 presented, then 0,1,3 pending -> 1,3,0.
        do_reset();
        step(4'b0001, 1'b0, 1'b0);
        wait_valid("rr_wait");
        for (int i = 0; i < DB + 4; i++) step(4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < DB + 4; i++) step(4'b1011, 1'b0, 1'b0);
        check("rr_pending", 32'(bus.pending), 32'b1011);
        ids.delete();
        step(4'b1011, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b1011, 1'b1, 1'b0);
            ids.push_back(int'(bus.evt_id));
        end
        check("rr_g1", 32'(ids[0]), 32'd1);
        check("rr_g2", 32'(ids[1]), 32'd3);
        check("rr_g3", 32'(ids[2]), 32'd0);
        for (int i = 0; i < 12; i++) step(4'b0000, 1'b1, 1'b0);

        // Coalescing: two further presses of button 0 under backpressure.
        do_reset();
        step(4'b0001, 1'b0, 1'b0);
        wait_valid("co_wait");
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DB + 4; i++) step(4'b0000, 1'b0, 1'b0);
            for (int i = 0; i < DB + 4; i++) step(4'b0001, 1'b0, 1'b0);
        end
        for (int i = 0; i < DB + 4; i++) step(4'b0000, 1'b0, 1'b0);
        check("co_pending", 32'(bus.pending[0]), 32'd1);
        check("co_drops", 32'(bus.drop_count), 32'd1);
        cnt_ev = 0;
        for (int i = 0; i < 10; i++) begin
            step(4'b0000, 1'b1, 1'b0);
            if (bus.evt_valid && bus.evt_id == 2'd0) cnt_ev++;
        end
        check("co_events", 32'(cnt_ev), 32'd2);
        check("co_stateful", 32'(bus.stateful[0]), 32'd0);

        // Reset while an event is presented.
        do_reset();
        step(4'b0100, 1'b0, 1'b0);
        wait_valid("mr_wait");
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        check("mr_valid", 32'(bus.evt_valid), 32'd0);
        check("mr_stateful", 32'(bus.stateful), 32'd0);
        check("mr_pending", 32'(bus.pending), 32'd0);

        // Random bouncing buttons with random readiness and rare resets.
        level = '0;
        for (int c = 0; c < 5000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(15) == 0) level[i] = ~level[i];
                b_rand[i] = level[i] ^ ($urandom_range(9) == 0);
            end
            step(b_rand, ((c / 400) % 2 == 0) ? ($urandom_range(7) == 0) : ($urandom_range(1) == 0),
                 $urandom_range(1999) == 0);
        end
        step('0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
